// File: rtl/sleep_stage_avg.sv
// Output stage: collects one softmax vector per inference, averages each stage over a short
// history, and strobes the argmax stage. History averaging is enabled by defining OUT_AVG_EN.
module sleep_stage_avg #(
    parameter int unsigned N_STORAGE               = 16,
    parameter int unsigned N_COMP                  = 22,
    parameter int unsigned Q                       = 10,
    parameter int unsigned NUM_SLEEP_STAGES        = 5,
    parameter int unsigned NUM_SAMPLES_OUT_AVG     = 3,
    parameter int unsigned INV_NUM_SAMPLES_OUT_AVG = 341
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 prob_valid,
    input  logic [N_STORAGE-1:0] prob_data,
    output logic                 prob_ready,
    input  logic                 clear_hist,
    output logic                 stage_valid,
    output logic [2:0]           stage,
    output logic [N_STORAGE-1:0] stage_prob,
    output logic                 busy
);

    localparam int unsigned IdxW = $clog2(NUM_SLEEP_STAGES);
    localparam int unsigned CntW = $clog2(NUM_SAMPLES_OUT_AVG + 1);
    localparam int unsigned PtrW = (NUM_SAMPLES_OUT_AVG > 1) ? $clog2(NUM_SAMPLES_OUT_AVG) : 1;
    localparam int unsigned PW   = 2 * N_COMP;
`ifdef OUT_AVG_EN
    localparam int unsigned Depth = NUM_SAMPLES_OUT_AVG;
`else
    localparam int unsigned Depth = 1;
`endif

    localparam logic [IdxW-1:0]        LastIdx = IdxW'(NUM_SLEEP_STAGES - 1);
    localparam logic signed [N_COMP-1:0] InvC  = N_COMP'(INV_NUM_SAMPLES_OUT_AVG);
    localparam logic signed [PW-1:0]   SatMax  = PW'(2 ** (N_STORAGE - 1) - 1);
    localparam logic signed [PW-1:0]   SatMin  = ~SatMax;

    typedef enum logic [1:0] {StIdle, StCollect, StAverage, StDone} state_e;

    state_e                      state_q, state_d;
    logic signed [N_STORAGE-1:0] hist_q [Depth][NUM_SLEEP_STAGES];
    logic signed [N_STORAGE-1:0] hist_d [Depth][NUM_SLEEP_STAGES];
    logic [IdxW-1:0]             idx_q, idx_d;
    logic [IdxW-1:0]             s_q, s_d;
    logic [IdxW-1:0]             max_idx_q, max_idx_d;
    logic signed [N_STORAGE-1:0] max_val_q, max_val_d;
    logic [2:0]                  stage_q, stage_d;
    logic signed [N_STORAGE-1:0] stage_prob_q, stage_prob_d;
    logic [CntW-1:0]             hist_cnt;
`ifdef OUT_AVG_EN
    logic [CntW-1:0]             hist_cnt_q, hist_cnt_d;
    logic [PtrW-1:0]             wr_ptr_q, wr_ptr_d;

    assign hist_cnt = hist_cnt_q;
`else
    // Constant count folds the shift and multiplier paths away.
    assign hist_cnt = CntW'(1);
`endif

    logic                        xfer;
    logic                        new_max;
    logic signed [N_COMP-1:0]    sum;
    logic signed [PW-1:0]        prod;
    logic signed [PW-1:0]        avg_wide;
    logic signed [N_STORAGE-1:0] avg_sat;

    assign prob_ready  = (state_q == StIdle) || (state_q == StCollect);
    assign stage_valid = (state_q == StDone);
    assign busy        = (state_q != StIdle);
    assign stage       = stage_q;
    assign stage_prob  = stage_prob_q;
    assign xfer        = prob_valid & prob_ready & ~clear_hist;

    // Average of stage s_q over the valid history slots.
    always_comb begin
        sum = '0;
        for (int k = 0; k < int'(Depth); k++) begin
            if (k < int'(hist_cnt)) begin
                sum = sum + N_COMP'(hist_q[k][s_q]);
            end
        end
        prod = PW'(sum) * PW'(InvC);
        if (hist_cnt == CntW'(1)) begin
            avg_wide = PW'(sum);
        end else if (hist_cnt == CntW'(2)) begin
            avg_wide = PW'(sum >>> 1);
        end else begin
            avg_wide = prod >>> Q;
        end
        if (avg_wide > SatMax) begin
            avg_sat = SatMax[N_STORAGE-1:0];
        end else if (avg_wide < SatMin) begin
            avg_sat = SatMin[N_STORAGE-1:0];
        end else begin
            avg_sat = avg_wide[N_STORAGE-1:0];
        end
        new_max = (s_q == '0) || (avg_sat > max_val_q);
    end

    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        idx_d        = idx_q;
        s_d          = s_q;
        max_idx_d    = max_idx_q;
        max_val_d    = max_val_q;
        stage_d      = stage_q;
        stage_prob_d = stage_prob_q;
`ifdef OUT_AVG_EN
        hist_cnt_d   = hist_cnt_q;
        wr_ptr_d     = wr_ptr_q;
`endif
        unique case (state_q)
            StIdle, StCollect: begin
                if (xfer) begin
`ifdef OUT_AVG_EN
                    hist_d[wr_ptr_q][idx_q] = $signed(prob_data);
`else
                    hist_d[0][idx_q] = $signed(prob_data);
`endif
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        s_d     = '0;
                        state_d = StAverage;
`ifdef OUT_AVG_EN
                        if (hist_cnt_q != CntW'(NUM_SAMPLES_OUT_AVG)) begin
                            hist_cnt_d = hist_cnt_q + 1'b1;
                        end
                        wr_ptr_d = (wr_ptr_q == PtrW'(NUM_SAMPLES_OUT_AVG - 1)) ?
                                   '0 : wr_ptr_q + 1'b1;
`endif
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StCollect;
                    end
                end
            end
            StAverage: begin
                if (new_max) begin
                    max_val_d = avg_sat;
                    max_idx_d = s_q;
                end
                if (s_q == LastIdx) begin
                    state_d      = StDone;
                    stage_d      = new_max ? 3'(s_q) : 3'(max_idx_q);
                    stage_prob_d = new_max ? avg_sat : max_val_q;
                end else begin
                    s_d = s_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Clear wins over everything, including a result about to be published.
        if (clear_hist) begin
            state_d      = StIdle;
            idx_d        = '0;
            s_d          = '0;
            stage_d      = stage_q;
            stage_prob_d = stage_prob_q;
`ifdef OUT_AVG_EN
            hist_cnt_d   = '0;
            wr_ptr_d     = '0;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            hist_q       <= '{default: '0};
            idx_q        <= '0;
            s_q          <= '0;
            max_idx_q    <= '0;
            max_val_q    <= '0;
            stage_q      <= '0;
            stage_prob_q <= '0;
`ifdef OUT_AVG_EN
            hist_cnt_q   <= '0;
            wr_ptr_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hist_q       <= hist_d;
            idx_q        <= idx_d;
            s_q          <= s_d;
            max_idx_q    <= max_idx_d;
            max_val_q    <= max_val_d;
            stage_q      <= stage_d;
            stage_prob_q <= stage_prob_d;
`ifdef OUT_AVG_EN
            hist_cnt_q   <= hist_cnt_d;
            wr_ptr_q     <= wr_ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_sleep_stage_avg.sv
// Bench for sleep_stage_avg: directed literal cases plus randomized inferences checked every
// cycle against a queue-based history model. Follows OUT_AVG_EN like the design.
module tb_sleep_stage_avg;

    typedef int inf_t[5];
`ifdef OUT_AVG_EN
    localparam int Depth = 3;
`else
    localparam int Depth = 1;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        prob_valid;
    logic [15:0] prob_data;
    logic        prob_ready;
    logic        clear_hist;
    logic        stage_valid;
    logic [2:0]  stage;
    logic [15:0] stage_prob;
    logic        busy;

    always #5 clk = ~clk;

    sleep_stage_avg dut (
        .clk        (clk),
        .rst        (rst),
        .prob_valid (prob_valid),
        .prob_data  (prob_data),
        .prob_ready (prob_ready),
        .clear_hist (clear_hist),
        .stage_valid(stage_valid),
        .stage      (stage),
        .stage_prob (stage_prob),
        .busy       (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: finished inferences, the one being collected, and cycles since its last word.
    inf_t m_hist[$];
    inf_t m_cur;
    int   m_in    = 0;
    int   m_phase = 0;
    int   m_stage = 0;
    int   m_prob  = 0;
    int   m_res_stage, m_res_prob;
    int   strobe_cnt = 0;
    int   last_stage = 0;
    int   last_prob  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int stage_avg(input int s);
        int sum = 0;
        int a;
        int n = m_hist.size();
        foreach (m_hist[k]) sum += m_hist[k][s];
        if (n == 1) a = sum;
        else if (n == 2) a = sum >>> 1;
        else a = (sum * 341) >>> 10;
        if (a > 32767) a = 32767;
        if (a < -32768) a = -32768;
        return a;
    endfunction

    task automatic model_result(output int st, output int pr);
        st = 0;
        pr = stage_avg(0);
        for (int s = 1; s < 5; s++) begin
            if (stage_avg(s) > pr) begin
                st = s;
                pr = stage_avg(s);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            m_hist.delete();
            m_in    = 0;
            m_phase = 0;
            m_stage = 0;
            m_prob  = 0;
        end
        check("prob_ready", int'(prob_ready), int'(m_phase == 0));
        check("stage_valid", int'(stage_valid), int'(m_phase == 6));
        check("busy", int'(busy), int'((m_phase != 0) || (m_in != 0)));
        check("stage", int'(stage), m_stage);
        check("stage_prob", int'($signed(stage_prob)), m_prob);
        if (stage_valid) begin
            strobe_cnt++;
            last_stage = int'(stage);
            last_prob  = int'($signed(stage_prob));
        end
        if (!rst) begin
            if (clear_hist) begin
                m_hist.delete();
                m_in    = 0;
                m_phase = 0;
            end else if (m_phase != 0) begin
                m_phase = (m_phase == 6) ? 0 : m_phase + 1;
                if (m_phase == 6) begin
                    m_stage = m_res_stage;
                    m_prob  = m_res_prob;
                end
            end else if (prob_valid) begin
                m_cur[m_in] = int'($signed(prob_data));
                m_in++;
                if (m_in == 5) begin
                    m_hist.push_back(m_cur);
                    if (m_hist.size() > Depth) void'(m_hist.pop_front());
                    model_result(m_res_stage, m_res_prob);
                    m_phase = 1;
                    m_in    = 0;
                end
            end
        end
    end

    // Drivers assume they start just after a rising edge.
    task automatic send_word(input int v, input int max_gap);
        bit acc;
        prob_valid = 1'b0;
        repeat ($urandom_range(0, max_gap)) begin
            @(posedge clk);
            #1;
        end
        prob_valid = 1'b1;
        prob_data  = 16'(v);
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            acc = prob_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            if (t == 49) check("send_timeout", 0, 1);
        end
        prob_valid = 1'b0;
    endtask

    task automatic send(input inf_t v, input int max_gap);
        for (int i = 0; i < 5; i++) send_word(v[i], max_gap);
    endtask

    task automatic clear_pulse(input bit with_valid);
        clear_hist = 1'b1;
        prob_valid = with_valid;
        prob_data  = 16'd77;
        @(posedge clk);
        #1;
        clear_hist = 1'b0;
        prob_valid = 1'b0;
    endtask

    // Waits for the next strobe, reports cycles from the last accepted word.
    task automatic wait_strobe(output int cycles);
        int c0 = strobe_cnt;
        cycles = 0;
        while (strobe_cnt == c0 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (strobe_cnt == c0) check("strobe_timeout", 0, 1);
    endtask

    task automatic expect_result(input string name, input int st, input int pr);
        int lat;
        wait_strobe(lat);
        check({name, "_latency"}, lat, 6);
        check({name, "_stage"}, last_stage, st);
        check({name, "_prob"}, last_prob, pr);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        inf_t v;
        int   c0;
        rst        = 1'b1;
        prob_valid = 1'b0;
        prob_data  = '0;
        clear_hist = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_ready", int'(prob_ready), 1);
        check("rst_valid", int'(stage_valid), 0);
        check("rst_stage", int'(stage), 0);
        check("rst_prob", int'(stage_prob), 0);
        check("rst_busy", int'(busy), 0);

        v = '{100, 200, 700, 24, 0};
        send(v, 0);
        expect_result("inf1", 2, 700);
        v = '{900, 50, 50, 24, 0};
        send(v, 1);
`ifdef OUT_AVG_EN
        expect_result("inf2", 0, 500);
        send(v, 0);
        expect_result("inf3", 0, 632);
        v = '{0, 0, 0, 1024, 0};
        send(v, 2);
        expect_result("inf4", 0, 599);
`else
        expect_result("inf2", 0, 900);
        send(v, 0);
        expect_result("inf3", 0, 900);
        v = '{0, 0, 0, 1024, 0};
        send(v, 2);
        expect_result("inf4", 3, 1024);
`endif
        clear_pulse(1'b1);
        v = '{512, 512, 0, 0, 0};
        send(v, 0);
        expect_result("tie", 0, 512);

        // Clear after two words, with a word offered in the clear cycle.
        c0 = strobe_cnt;
        send_word(11, 0);
        send_word(22, 0);
        clear_pulse(1'b1);
        repeat (10) @(posedge clk);
        #1;
        check("clear_no_strobe", strobe_cnt - c0, 0);
        v = '{10, 20, 30, 40, 999};
        send(v, 0);
        expect_result("after_clear", 4, 999);

        // Reset while averaging.
        v = '{300, 300, 300, 300, 300};
        send(v, 0);
        c0 = strobe_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("rst_no_strobe", strobe_cnt - c0, 0);
        v = '{-50, 0, 60, 60, 5};
        send(v, 0);
        expect_result("after_rst", 2, 60);

        for (int n = 0; n < 60; n++) begin
            for (int i = 0; i < 5; i++) begin
                v[i] = int'($urandom_range(0, 3000)) - 1000;
            end
            for (int i = 0; i < 5; i++) begin
                send_word(v[i], 2);
                if ($urandom_range(0, 39) == 0) clear_pulse(1'($urandom_range(0, 1)));
            end
            repeat ($urandom_range(0, 8)) @(posedge clk);
            #1;
        end
        repeat (12) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
